mux_rr_reg: RTL

- Parametrised successor to the team's 2:1 gate-level select block.
- Selects one of N_CH input channels of WIDTH bits onto a single registered output with a valid/ready handshake.
- Two modes: fixed select (sel_in chooses the channel) and round-robin arbitration across valid channels.
- Sits between multiple producers and one consumer in the datapath; one output register stage, no buffering beyond it.

---
 rtl/mux_rr_pkg.sv | 7 +
 rtl/mux_rr_reg_rr_pick.sv | 36 +++
 rtl/mux_rr_reg.sv | 86 ++++++++
 3 files changed

// File: rtl/mux_rr_pkg.sv
// Shared constants for the registered N-channel select/arbitration block.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : mux_rr_pkg

// File: rtl/mux_rr_reg_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning cyclically from
// ptr+1 through ptr itself (ptr is the previous winner, so it has lowest priority).
module rr_pick #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // cand[gi] is the channel examined at scan position gi (0 = highest priority).
  logic [SEL_W-1:0] cand [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
      assign cand[gi] = (int'(ptr) + gi + 1 >= N_CH)
                        ? SEL_W'(int'(ptr) + gi + 1 - N_CH)
                        : SEL_W'(int'(ptr) + gi + 1);
    end
  endgenerate

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[i];
      end
    end
  end

endmodule : rr_pick

// File: rtl/mux_rr_reg.sv
// N-channel to one registered output mux with valid/ready handshake; fixed-select
// or round-robin arbitration, one output register stage with full throughput.
module mux_rr_reg
  import mux_rr_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  mode_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH*WIDTH-1:0] data_in,
  input  logic [N_CH-1:0]       valid_in,
  output logic [N_CH-1:0]       ready_out,
  output logic [WIDTH-1:0]      y_out,
  output logic                  y_valid_out,
  output logic [SEL_W-1:0]      y_ch_out,
  input  logic                  y_ready_in
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [WIDTH-1:0]    ch_data [N_CH];
  logic [SEL_SPAN-1:0] valid_ext;
  logic [SEL_W-1:0]    rr_ptr_reg;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_vld;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic                fixed_vld;
  logic                can_load;
  logic                xfer;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pad valid_in to the full index range so an out-of-range sel_in reads a zero.
  always_comb begin
    valid_ext = '0;
    valid_ext[N_CH-1:0] = valid_in;
  end

  assign fixed_vld = valid_ext[sel_in];

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (valid_in),
    .ptr     (rr_ptr_reg),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign gnt_vld  = (mode_in == MODE_RR) ? rr_vld : fixed_vld;
  assign gnt_idx  = (mode_in == MODE_RR) ? rr_idx : sel_in;
  assign can_load = !y_valid_out || y_ready_in;
  assign xfer     = gnt_vld && can_load && !rst_in;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
      assign ready_out[gi] = xfer && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      y_out       <= '0;
      y_valid_out <= 1'b0;
      y_ch_out    <= '0;
      rr_ptr_reg  <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      y_out       <= ch_data[gnt_idx];
      y_ch_out    <= gnt_idx;
      y_valid_out <= 1'b1;
      if (mode_in == MODE_RR) begin
        rr_ptr_reg <= gnt_idx;
      end
    end else if (y_ready_in) begin
      y_valid_out <= 1'b0;
    end
  end

endmodule : mux_rr_reg
